// File: rtl/demux_event_counter_if.sv
// demux_event_counter_if
//   Bundles the data-path signals of demux_event_counter so the counter and
//   whatever drives it (demux-side logic or a bench) share one connection.
//
//   Parameter:
//     CNT_W       width of the read-back counter value (must match the
//                 CNT_W of the attached demux_event_counter)
//
//   Signals (direction seen from the counter, i.e. the slave modport):
//     y_in        in   8      demux outputs Y[7:0], expected one-hot or zero
//     clr         in   1      synchronous clear of counters, sat flags, error
//     rd_en       in   1      one-cycle read request
//     rd_sel      in   3      channel to read
//     rd_data     out  CNT_W  counter value of the channel read
//     rd_valid    out  1      one-cycle pulse qualifying rd_data
//     active_ch   out  3      index of the single high channel
//     active_vld  out  1      exactly one registered input bit is high
//     sat         out  8      sticky per-channel saturation flags
//     any_sat     out  1      OR of sat
//     onehot_err  out  1      sticky multi-hot error flag
interface demux_event_counter_if #(
   parameter int CNT_W = 8
);

   logic [7:0]       y_in;
   logic             clr;
   logic             rd_en;
   logic [2:0]       rd_sel;
   logic [CNT_W-1:0] rd_data;
   logic             rd_valid;
   logic [2:0]       active_ch;
   logic             active_vld;
   logic [7:0]       sat;
   logic             any_sat;
   logic             onehot_err;

   // The master drives events and read requests and observes the results.
   modport master (
      output y_in, clr, rd_en, rd_sel,
      input  rd_data, rd_valid, active_ch, active_vld, sat, any_sat, onehot_err
   );

   // The counter block itself.
   modport slave (
      input  y_in, clr, rd_en, rd_sel,
      output rd_data, rd_valid, active_ch, active_vld, sat, any_sat, onehot_err
   );

endinterface

// File: rtl/demux_event_counter.sv
// demux_event_counter
//   Per-channel event counter placed directly after the 1-to-8 demultiplexer.
//   The demux outputs are registered twice; a channel counts once per rising
//   edge of its registered level. Each channel owns a saturating counter and
//   a sticky saturation flag. The block also decodes the single active
//   channel, flags multi-hot input patterns, and offers a registered read
//   port returning one counter per request with one cycle of latency.
//
//   Parameters:
//     CNT_W        counter width; counters saturate at 2^CNT_W-1
//     CLR_ON_READ  1 = a read zeroes the selected counter, 0 = reads are
//                  non-destructive
//
//   Ports:
//     clk   in     single clock, all state updates on its rising edge
//     rst   in     synchronous active-high reset
//     bus   slave  demux_event_counter_if (events, clear, read port, status)
module demux_event_counter #(
   parameter int CNT_W       = 8,
   parameter bit CLR_ON_READ = 1'b0
) (
   input logic                  clk,
   input logic                  rst,
   demux_event_counter_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [7:0]       y_q;
   logic [7:0]       y_prev;
   logic [7:0]       rise;
   logic [CNT_W-1:0] cnt [8];
   logic [7:0]       sat_q;
   logic             onehot_err_q;
   logic [3:0]       pop;
   logic [2:0]       last_idx;
   logic             single_hot;
   logic [CNT_W-1:0] rd_data_q;
   logic             rd_valid_q;

   // Input stage: the current and previous registered demux levels. Reset
   // zeroes both, so a channel held high across reset release produces
   // exactly one edge. clr deliberately leaves this history alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q    <= '0;
         y_prev <= '0;
      end else begin
         y_q    <= bus.y_in;
         y_prev <= y_q;
      end
   end

   assign rise = y_q & ~y_prev;

   // Population count of the registered level plus the index of its highest
   // set bit. The index is only meaningful when exactly one bit is set.
   always_comb begin
      pop      = '0;
      last_idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (y_q[i]) begin
            pop      = pop + 4'd1;
            last_idx = 3'(i);
         end
      end
   end

   assign single_hot = (pop == 4'd1);

   // Per-channel counters and sticky saturation flags. clr and rst win over
   // everything. With clear-on-read, the channel being read restarts at 0,
   // or at 1 when it also rises this cycle so that edge is not lost; its
   // saturation flag is left as it is. An edge arriving at full scale holds
   // the counter and marks the channel saturated.
   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         for (int i = 0; i < 8; i++) begin
            cnt[i] <= '0;
         end
         sat_q <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (CLR_ON_READ && bus.rd_en && (bus.rd_sel == 3'(i))) begin
               cnt[i] <= rise[i] ? CNT_ONE : '0;
            end else if (rise[i]) begin
               if (cnt[i] == CNT_MAX) begin
                  sat_q[i] <= 1'b1;
               end else begin
                  cnt[i] <= cnt[i] + CNT_ONE;
               end
            end
         end
      end
   end

   // Sticky multi-hot error: any registered pattern with two or more bits
   // set trips it until the next clr or rst.
   always_ff @(posedge clk) begin
      if (rst || bus.clr) begin
         onehot_err_q <= 1'b0;
      end else if (pop >= 4'd2) begin
         onehot_err_q <= 1'b1;
      end
   end

   // Read port: captures the counter value as it stood before this edge, so
   // a read coinciding with clr still returns the pre-clear value. rd_data
   // holds between reads; only rst zeroes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) begin
            rd_data_q <= cnt[bus.rd_sel];
         end
      end
   end

   assign bus.active_vld = single_hot;
   assign bus.active_ch  = single_hot ? last_idx : 3'd0;
   assign bus.sat        = sat_q;
   assign bus.any_sat    = |sat_q;
   assign bus.onehot_err = onehot_err_q;
   assign bus.rd_data    = rd_data_q;
   assign bus.rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_demux_event_counter.sv
// tb_demux_event_counter
//   Drives two counters from the same stimulus: one with non-destructive
//   reads and one with clear-on-read. A behavioural model keeps integer
//   event counts per channel and the last two samples of y_in, and every
//   cycle the outputs of both instances are compared with it. A constant
//   vector table and hand-written sequences cover the directed cases; a
//   randomized phase runs last.
module tb_demux_event_counter;

   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] y_in_drv;
   logic       clr_drv;
   logic       rd_en_drv;
   logic [2:0] rd_sel_drv;

   int checks   = 0;
   int failures = 0;

   int         m_cnt [2][8];
   logic [7:0] m_sat [2];
   logic       m_err;
   logic [7:0] samp_now;
   logic [7:0] samp_old;
   logic       m_rd_valid;
   int         m_rd_data [2];

   typedef struct {
      logic [7:0] y;
      logic       clr;
      logic       rd_en;
      logic [2:0] rd_sel;
      logic       exp_rd_valid;
      logic [7:0] exp_rd_data;
      logic       exp_act_vld;
      logic [2:0] exp_act_ch;
      logic       exp_err;
   } vec_t;

   vec_t vecs [10];

   always #5 clk = ~clk;

   demux_event_counter_if #(.CNT_W(CNT_W)) bus0 ();
   demux_event_counter_if #(.CNT_W(CNT_W)) bus1 ();

   assign bus0.y_in   = y_in_drv;
   assign bus0.clr    = clr_drv;
   assign bus0.rd_en  = rd_en_drv;
   assign bus0.rd_sel = rd_sel_drv;
   assign bus1.y_in   = y_in_drv;
   assign bus1.clr    = clr_drv;
   assign bus1.rd_en  = rd_en_drv;
   assign bus1.rd_sel = rd_sel_drv;

   demux_event_counter #(.CNT_W(CNT_W), .CLR_ON_READ(1'b0)) dut_nd (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   demux_event_counter #(.CNT_W(CNT_W), .CLR_ON_READ(1'b1)) dut_cor (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Advance the reference model by one clock edge with the given inputs.
   task automatic model_edge(input logic [7:0] y, input logic c, input logic re,
                             input logic [2:0] rs, input logic r);
      logic [7:0] went_high;
      went_high = samp_now & ~samp_old;
      if (r) begin
         for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 8; i++) m_cnt[v][i] = 0;
            m_sat[v]     = 8'h00;
            m_rd_data[v] = 0;
         end
         m_err      = 1'b0;
         m_rd_valid = 1'b0;
         samp_now   = 8'h00;
         samp_old   = 8'h00;
         return;
      end
      m_rd_valid = re;
      for (int v = 0; v < 2; v++) begin
         if (re) m_rd_data[v] = m_cnt[v][rs];
      end
      if (c) begin
         for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 8; i++) m_cnt[v][i] = 0;
            m_sat[v] = 8'h00;
         end
         m_err = 1'b0;
      end else begin
         for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < 8; i++) begin
               if (v == 1 && re && int'(rs) == i) begin
                  m_cnt[v][i] = went_high[i] ? 1 : 0;
               end else if (went_high[i]) begin
                  if (m_cnt[v][i] >= CNT_MAX) m_sat[v][i] = 1'b1;
                  else m_cnt[v][i] = m_cnt[v][i] + 1;
               end
            end
         end
         if ($countones(samp_now) >= 2) m_err = 1'b1;
      end
      samp_old = samp_now;
      samp_now = y;
   endtask

   task automatic compare_one(input string tag, input int v, input logic rv,
                              input logic [7:0] rd, input logic av, input logic [2:0] ac,
                              input logic [7:0] s, input logic as, input logic oe);
      logic       exp_vld;
      logic [2:0] exp_ch;
      exp_vld = ($countones(samp_now) == 1);
      exp_ch  = 3'd0;
      if (exp_vld) begin
         for (int i = 0; i < 8; i++) if (samp_now[i]) exp_ch = 3'(i);
      end
      checkOutput({tag, "_rd_valid"}, 32'(rv), 32'(m_rd_valid));
      checkOutput({tag, "_rd_data"}, 32'(rd), m_rd_data[v]);
      checkOutput({tag, "_active_vld"}, 32'(av), 32'(exp_vld));
      checkOutput({tag, "_active_ch"}, 32'(ac), 32'(exp_ch));
      checkOutput({tag, "_sat"}, 32'(s), 32'(m_sat[v]));
      checkOutput({tag, "_any_sat"}, 32'(as), 32'(m_sat[v] != 8'h00));
      checkOutput({tag, "_onehot_err"}, 32'(oe), 32'(m_err));
   endtask

   // One clock: drive inputs, step the model, sample #1 after the edge.
   task automatic applyStimulus(input logic [7:0] y, input logic c, input logic re,
                                input logic [2:0] rs, input logic r);
      y_in_drv   = y;
      clr_drv    = c;
      rd_en_drv  = re;
      rd_sel_drv = rs;
      rst        = r;
      model_edge(y, c, re, rs, r);
      @(posedge clk);
      #1;
      compare_one("nd", 0, bus0.rd_valid, bus0.rd_data, bus0.active_vld, bus0.active_ch,
                  bus0.sat, bus0.any_sat, bus0.onehot_err);
      compare_one("cor", 1, bus1.rd_valid, bus1.rd_data, bus1.active_vld, bus1.active_ch,
                  bus1.sat, bus1.any_sat, bus1.onehot_err);
   endtask

   task automatic hold(input logic [7:0] y, input int n);
      for (int i = 0; i < n; i++) applyStimulus(y, 1'b0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic read_ch(input logic [7:0] y, input logic [2:0] s);
      applyStimulus(y, 1'b0, 1'b1, s, 1'b0);
   endtask

   task automatic do_reset();
      applyStimulus(8'hFF, 1'b0, 1'b1, 3'd5, 1'b1);
      applyStimulus(8'h00, 1'b0, 1'b0, 3'd0, 1'b1);
   endtask

   initial begin
      logic [7:0] ry;

      vecs[0] = '{8'h01, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b1, 3'd0, 1'b0};
      vecs[1] = '{8'h01, 1'b0, 1'b1, 3'd0, 1'b1, 8'd0, 1'b1, 3'd0, 1'b0};
      vecs[2] = '{8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 8'd1, 1'b0, 3'd0, 1'b0};
      vecs[3] = '{8'h04, 1'b0, 1'b0, 3'd0, 1'b0, 8'd1, 1'b1, 3'd2, 1'b0};
      vecs[4] = '{8'h0C, 1'b0, 1'b0, 3'd0, 1'b0, 8'd1, 1'b0, 3'd0, 1'b0};
      vecs[5] = '{8'h00, 1'b0, 1'b1, 3'd2, 1'b1, 8'd1, 1'b0, 3'd0, 1'b1};
      vecs[6] = '{8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 8'd1, 1'b0, 3'd0, 1'b1};
      vecs[7] = '{8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 8'd1, 1'b0, 3'd0, 1'b0};
      vecs[8] = '{8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 8'd0, 1'b0, 3'd0, 1'b0};
      vecs[9] = '{8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b0};

      rst        = 1'b1;
      y_in_drv   = 8'h00;
      clr_drv    = 1'b0;
      rd_en_drv  = 1'b0;
      rd_sel_drv = 3'd0;

      $display("[TB] reset values");
      do_reset();
      checkOutput("reset_rd_data", 32'(bus0.rd_data), 32'd0);
      checkOutput("reset_rd_valid", 32'(bus0.rd_valid), 32'd0);
      checkOutput("reset_active_vld", 32'(bus0.active_vld), 32'd0);
      checkOutput("reset_sat", 32'(bus0.sat), 32'd0);
      checkOutput("reset_onehot_err", 32'(bus0.onehot_err), 32'd0);

      $display("[TB] vector table");
      for (int k = 0; k < 10; k++) begin
         applyStimulus(vecs[k].y, vecs[k].clr, vecs[k].rd_en, vecs[k].rd_sel, 1'b0);
         checkOutput($sformatf("vec%0d_rd_valid", k), 32'(bus0.rd_valid), 32'(vecs[k].exp_rd_valid));
         checkOutput($sformatf("vec%0d_rd_data", k), 32'(bus0.rd_data), 32'(vecs[k].exp_rd_data));
         checkOutput($sformatf("vec%0d_act_vld", k), 32'(bus0.active_vld), 32'(vecs[k].exp_act_vld));
         checkOutput($sformatf("vec%0d_act_ch", k), 32'(bus0.active_ch), 32'(vecs[k].exp_act_ch));
         checkOutput($sformatf("vec%0d_err", k), 32'(bus0.onehot_err), 32'(vecs[k].exp_err));
      end

      $display("[TB] sequential sweep");
      do_reset();
      for (int rep = 0; rep < 3; rep++) begin
         for (int ch = 0; ch < 8; ch++) begin
            applyStimulus(8'(1 << ch), 1'b0, 1'b0, 3'd0, 1'b0);
            checkOutput("sweep_active_ch", 32'(bus0.active_ch), ch);
            hold(8'(1 << ch), 9);
            hold(8'h00, 2);
         end
      end
      for (int ch = 0; ch < 8; ch++) begin
         read_ch(8'h00, 3'(ch));
         checkOutput("sweep_nd_count", 32'(bus0.rd_data), 32'd3);
         checkOutput("sweep_cor_count", 32'(bus1.rd_data), 32'd3);
      end
      checkOutput("sweep_onehot_err", 32'(bus0.onehot_err), 32'd0);

      $display("[TB] saturation");
      do_reset();
      for (int t = 0; t < 300; t++) begin
         hold(8'h20, 1);
         hold(8'h00, 1);
      end
      read_ch(8'h00, 3'd5);
      checkOutput("sat_rd_data", 32'(bus0.rd_data), 32'd255);
      checkOutput("sat_flags", 32'(bus0.sat), 32'h20);
      checkOutput("sat_any", 32'(bus0.any_sat), 32'd1);
      applyStimulus(8'h00, 1'b1, 1'b0, 3'd0, 1'b0);
      checkOutput("sat_after_clr", 32'(bus0.sat), 32'h00);
      read_ch(8'h00, 3'd5);
      checkOutput("sat_cnt_after_clr", 32'(bus0.rd_data), 32'd0);

      $display("[TB] multi-hot");
      do_reset();
      hold(8'h00, 1);
      hold(8'h81, 1);
      checkOutput("multi_active_vld", 32'(bus0.active_vld), 32'd0);
      hold(8'h00, 1);
      checkOutput("multi_err_set", 32'(bus0.onehot_err), 32'd1);
      hold(8'h00, 3);
      checkOutput("multi_err_sticky", 32'(bus0.onehot_err), 32'd1);
      read_ch(8'h00, 3'd0);
      checkOutput("multi_ch0", 32'(bus0.rd_data), 32'd1);
      read_ch(8'h00, 3'd7);
      checkOutput("multi_ch7", 32'(bus0.rd_data), 32'd1);

      $display("[TB] read/increment collision");
      do_reset();
      for (int t = 0; t < 4; t++) begin
         hold(8'h04, 1);
         hold(8'h00, 1);
      end
      hold(8'h04, 1);
      read_ch(8'h04, 3'd2);
      checkOutput("collide_cor_first", 32'(bus1.rd_data), 32'd4);
      hold(8'h00, 1);
      read_ch(8'h00, 3'd2);
      checkOutput("collide_cor_second", 32'(bus1.rd_data), 32'd1);
      checkOutput("collide_nd_second", 32'(bus0.rd_data), 32'd5);

      $display("[TB] clr vs increment");
      hold(8'h08, 1);
      applyStimulus(8'h08, 1'b1, 1'b0, 3'd0, 1'b0);
      hold(8'h00, 1);
      read_ch(8'h00, 3'd3);
      checkOutput("clr_inc_nd", 32'(bus0.rd_data), 32'd0);
      checkOutput("clr_inc_cor", 32'(bus1.rd_data), 32'd0);

      $display("[TB] reset mid-operation");
      for (int t = 0; t < 260; t++) begin
         hold(8'h40, 1);
         hold(8'h00, 1);
      end
      checkOutput("rst_mid_presat", 32'(bus0.sat), 32'h40);
      hold(8'h10, 3);
      applyStimulus(8'h10, 1'b0, 1'b1, 3'd4, 1'b1);
      checkOutput("rst_mid_rd_valid", 32'(bus0.rd_valid), 32'd0);
      checkOutput("rst_mid_sat", 32'(bus0.sat), 32'h00);
      hold(8'h10, 2);
      read_ch(8'h10, 3'd4);
      checkOutput("rst_mid_ch4_nd", 32'(bus0.rd_data), 32'd1);
      checkOutput("rst_mid_ch4_cor", 32'(bus1.rd_data), 32'd1);

      $display("[TB] randomized");
      do_reset();
      ry = 8'h00;
      for (int t = 0; t < 2500; t++) begin
         if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 9))
               0, 1, 2: ry = 8'h00;
               9:       ry = 8'($urandom);
               default: ry = 8'(1 << $urandom_range(0, 7));
            endcase
         end
         applyStimulus(ry, ($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                       3'($urandom_range(0, 7)), ($urandom_range(0, 299) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
